// File: rtl/multicycle_control.sv
// LEGv8 multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared memory, plus a retired-instruction counter.
// Latency with MemReady=1: R/I/ST 4, LD 5, CB/B 3 cycles. FETCH and MEM hold while MemReady=0.
module multicycle_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [10:0]         Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCSrc,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IorD,
    output logic                MemtoReg,
    output logic                ALUSrc,
    output logic                Reg2Loc,
    output logic [1:0]          SignOp,
    output logic [1:0]          ALUOp,
    output logic                Illegal,
    output logic [2:0]          State,
    output logic [RETIRE_W-1:0] Retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LD, C_ST, C_CB, C_B, C_ILL
    } cls_t;

    state_t     state_q, state_d;
    cls_t       cls_q, dec_cls;
    logic [1:0] signop_q, signop_d;
    logic       retire;

    always_comb begin
        dec_cls = C_ILL;
        casez (Opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_cls = C_R;
            11'b1001000100?: dec_cls = C_I;
            11'b11111000010: dec_cls = C_LD;
            11'b11111000000: dec_cls = C_ST;
            11'b10110100???: dec_cls = C_CB;
            11'b000101?????: dec_cls = C_B;
            default:         dec_cls = C_ILL;
        endcase
    end

    always_comb begin
        signop_d = 2'b00;
        case (dec_cls)
            C_LD, C_ST: signop_d = 2'b01;
            C_CB:       signop_d = 2'b10;
            C_B:        signop_d = 2'b11;
            default:    signop_d = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= FETCH;
            cls_q    <= C_ILL;
            signop_q <= 2'b00;
            Retired  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                cls_q    <= dec_cls;
                signop_q <= signop_d;
            end
            if (retire) begin
                Retired <= Retired + RETIRE_W'(1);
            end
        end
    end

    // Reset gates every strobe combinationally so an in-flight memory request drops immediately.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        Reg2Loc  = 1'b0;
        ALUOp    = 2'b00;
        Illegal  = 1'b0;
        if (!Reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    if (dec_cls == C_ILL) begin
                        Illegal = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    case (cls_q)
                        C_R: begin
                            ALUOp   = 2'b10;
                            state_d = WB;
                        end
                        C_I: begin
                            ALUSrc  = 1'b1;
                            state_d = WB;
                        end
                        C_LD: begin
                            ALUSrc  = 1'b1;
                            state_d = MEM;
                        end
                        C_ST: begin
                            ALUSrc  = 1'b1;
                            Reg2Loc = 1'b1;
                            state_d = MEM;
                        end
                        C_CB: begin
                            ALUOp   = 2'b01;
                            Reg2Loc = 1'b1;
                            PCWrite = Zero;
                            PCSrc   = 1'b1;
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                        C_B: begin
                            PCWrite = 1'b1;
                            PCSrc   = 1'b1;
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                        default: state_d = FETCH;
                    endcase
                end
                MEM: begin
                    IorD     = 1'b1;
                    ALUSrc   = 1'b1;
                    MemRead  = (cls_q == C_LD);
                    MemWrite = (cls_q == C_ST);
                    if (MemReady) begin
                        if (cls_q == C_LD) begin
                            state_d = WB;
                        end else begin
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                    end
                end
                WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (cls_q == C_LD);
                    state_d  = FETCH;
                    retire   = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign SignOp = Reset ? 2'b00 : signop_q;
    assign State  = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the LEGv8 multicycle datapath. Sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory with a ready handshake. Drives the sign-extender mode select, ALU op class and all register/PC/memory strobes. Also keeps a retired-instruction counter for lab benches.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter

Ports:
CLK  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Opcode  input  11  Instruction[31:21] from the instruction register
Zero  input  1  ALU zero flag, valid during EXEC
MemReady  input  1  memory completes the current read/write this cycle
IRWrite  output  1  load instruction register
PCWrite  output  1  load PC
PCSrc  output  1  0 = PC+4, 1 = branch target (OldPC + SignExOut)
RegWrite  output  1  register file write enable
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IorD  output  1  0 = memory address from PC, 1 = from ALU result
MemtoReg  output  1  writeback source: 1 = memory data
ALUSrc  output  1  ALU B operand: 1 = SignExOut
Reg2Loc  output  1  1 = read register 2 from Rt field (STUR, CBZ)
SignOp  output  2  00 I-type, 01 D-type, 10 CB-type, 11 B-type
ALUOp  output  2  00 add, 01 pass B (CBZ test), 10 R-type funct
Illegal  output  1  one-cycle pulse on an undecodable opcode
State  output  3  current state encoding, for debug
Retired  output  RETIRE_W  count of completed instructions

Behaviour:
- Clock and reset are fixed: one clock, CLK; Reset is synchronous and active-high.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5-7 are unreachable and go to FETCH with all strobes 0.
- Reset: State=FETCH, Retired=0, class register=ILL. All strobes are 0 in the reset cycle. SignOp and ALUOp are 00.
- Reset mid-operation has priority over every transition. Any outstanding MemRead/MemWrite drops in the cycle Reset is sampled. No write strobe is asserted in that cycle.
- FETCH: MemRead=1, IorD=0. Hold while MemReady=0. On MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE. The datapath latches OldPC on IRWrite.
- DECODE: classify Opcode into a class register (x = don't care):
  - R: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR
  - I: 1001000100x ADDI
  - LD: 11111000010
  - ST: 11111000000
  - CB: 10110100xxx
  - B: 000101xxxxx
  - anything else is ILL
- DECODE next state: ILL pulses Illegal=1 and goes to FETCH, with no writes and no retire. Every other class goes to EXEC.
- SignOp is registered from the class in DECODE and held until the next DECODE: I=00, LD/ST=01, CB=10, B=11, R/ILL=00.
- EXEC, by class:
  - R: ALUOp=10, ALUSrc=0, then WB.
  - I: ALUOp=00, ALUSrc=1, then WB.
  - LD/ST: ALUOp=00, ALUSrc=1, Reg2Loc=1 for ST, then MEM.
  - CB: ALUOp=01, Reg2Loc=1. PCWrite=Zero (Mealy), PCSrc=1, then FETCH.
  - B: PCWrite=1, PCSrc=1, then FETCH.
- MEM: IorD=1. ALUOp/ALUSrc are held from EXEC so the address stays stable. MemRead=1 (LD) or MemWrite=1 (ST), held while MemReady=0. On MemReady: LD goes to WB, ST goes to FETCH.
- WB: RegWrite=1 for exactly one cycle, MemtoReg=1 for LD only, then FETCH.
- Retired increments by 1 on every transition into FETCH from EXEC, MEM or WB, including CB not taken. It wraps modulo 2^RETIRE_W and never increments on ILL or reset.
- Latency with MemReady tied to 1: R/I 4 cycles, LD 5, ST 4, CB/B 3. Each memory wait cycle adds 1 to FETCH or MEM.
- MemReady outside FETCH/MEM is ignored.
- Never assert MemRead and MemWrite together.
- Never assert RegWrite outside WB.

Test Plan:
- Reset high for 2 cycles mid-MEM of STUR -> next cycle State=0, MemWrite=0, Retired=0, all strobes 0.
- ADD (Opcode 10001011000), MemReady=1 -> States 0,1,2,4,0. RegWrite high one cycle in WB, ALUOp=10, Retired 0->1.
- LDUR with MemReady low 3 cycles in MEM -> MemRead/IorD held 4 MEM cycles. WB has MemtoReg=1, RegWrite=1. Total 8 cycles, SignOp=01.
- CBZ with Zero=0, then CBZ with Zero=1 -> PCWrite 0 then 1 in EXEC, PCSrc=1, SignOp=10. Retired +2 after both.
- B (Opcode 00010100000) -> 3 cycles, SignOp=11, PCWrite=PCSrc=1 in EXEC. ADDI -> SignOp=00, ALUSrc=1 in EXEC.
- Opcode 11111111111 -> Illegal pulses for exactly one cycle in DECODE. No RegWrite/MemWrite/PCWrite beyond FETCH, Retired unchanged. Preset Retired to all-ones, then retire one instruction -> Retired wraps to 0.
